// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the fetch FSM state encoding and the instruction size.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_DROP     = 2'd2
  } fetch_state_e;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue holding {pc, inst} pairs.
// Flush empties the queue and dominates any same-cycle push or pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [WIDTH-1:0]       o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC generation and single-outstanding instruction fetch with
// redirect handling and a small decoupling queue toward decode.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_tgt,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_tgt,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_req_pc;
  logic [XLEN-1:0]   w_redir_tgt;
  logic              w_redirect;
  logic              w_req_fire;
  logic              w_has_room;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count;
  logic [2*XLEN-1:0] w_head;

  assign w_redirect  = jump | branch_taken;
  assign w_redir_tgt = (jump ? jump_tgt : branch_tgt)
                     & ~XLEN'(INST_BYTES - 1);
  assign w_has_room  = (w_count < CW'(DEPTH));

  always_comb begin
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    w_push         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        imem_req_valid = w_has_room & ~w_redirect;
        if (w_has_room && !w_redirect && imem_req_ready) begin
          w_state_nxt = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (w_redirect) begin
          w_state_nxt = imem_rsp_valid ? ST_IDLE : ST_DROP;
        end else if (imem_rsp_valid) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_req_fire = imem_req_valid & imem_req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A redirect can never coincide with a request handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_fetch_pc <= w_redir_tgt;
    end else if (w_req_fire) begin
      r_fetch_pc <= r_fetch_pc + XLEN'(INST_BYTES);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_req_pc <= '0;
    else if (w_req_fire) r_req_pc <= r_fetch_pc;
  end

  assign imem_addr = r_fetch_pc;
  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid & out_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (w_push),
    .i_push_data ({r_req_pc, imem_rsp_data}),
    .i_pop       (w_pop),
    .i_flush     (w_redirect),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign out_pc   = w_head[2*XLEN-1:XLEN];
  assign out_inst = w_head[XLEN-1:0];

endmodule
